instr_fetch_responder: RTL

Responder end of the processor's instruction-address interface. It accepts the 8-bit `cur_add` instruction address issued by the sequencing side, detects each new address, fetches the instruction word from an internal loadable instruction store and presents it to the processor datapath for a fixed execution window with a valid flag. It sits between whatever drives `cur_add` (bench or hardware sequencer) and the `MIPS_Processor` decode/execute logic. It also provides busy status and an issue counter.

---
 rtl/instr_fetch_responder_if.sv | 31 +++
 rtl/instr_fetch_responder.sv | 111 +++++++++++
 2 files changed

// File: rtl/instr_fetch_responder_if.sv
// Instruction-address bus between the sequencing side (master) and the
// fetch responder (slave).
//   cur_add               : instruction address from the initiator
//   load_en/addr/data     : instruction-store write port
//   instr, instr_valid    : fetched word and its execution-window flag
//   issue                 : one-cycle pulse at the start of each window
//   busy, issue_count     : status
interface instr_fetch_responder_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 32
);
  logic [ADDR_W-1:0]  cur_add;
  logic               load_en;
  logic [ADDR_W-1:0]  load_addr;
  logic [INSTR_W-1:0] load_data;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               issue;
  logic               busy;
  logic [7:0]         issue_count;

  modport master (
    output cur_add, load_en, load_addr, load_data,
    input  instr, instr_valid, issue, busy, issue_count
  );

  modport slave (
    input  cur_add, load_en, load_addr, load_data,
    output instr, instr_valid, issue, busy, issue_count
  );
endinterface

// File: rtl/instr_fetch_responder.sv
// Instruction fetch responder. Watches cur_add; each time it differs from
// the last address taken (or after reset), the word is read from the
// internal store and held on instr for EXEC_CYCLES cycles with instr_valid.
// Address changes while busy are not queued: the address is re-compared on
// return to IDLE, so only the latest value matters.
// Ports:
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : instr_fetch_responder_if slave modport (see interface file)
module instr_fetch_responder #(
  parameter int ADDR_W      = 8,
  parameter int INSTR_W     = 32,
  parameter int EXEC_CYCLES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  instr_fetch_responder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_e;

  localparam logic [7:0] CNT_INIT = 8'(EXEC_CYCLES - 1);

  state_e             state_q, state_d;
  logic [ADDR_W-1:0]  last_add_q, last_add_d;
  logic               last_vld_q, last_vld_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic               instr_valid_q, instr_valid_d;
  logic               issue_q, issue_d;
  logic [7:0]         issue_count_q, issue_count_d;

  logic [INSTR_W-1:0] store [2**ADDR_W];
  logic [INSTR_W-1:0] store_rd;
  logic               store_we;

  // Store is not reset; writes are blocked while reset is held.
  assign store_we = bus.load_en & rst;
  assign store_rd = store[last_add_q];

  // Nonblocking write gives read-before-write against a same-cycle FETCH.
  always_ff @(posedge clk) begin
    if (store_we) store[bus.load_addr] <= bus.load_data;
  end

  always_comb begin
    state_d       = state_q;
    last_add_d    = last_add_q;
    last_vld_d    = last_vld_q;
    cnt_d         = cnt_q;
    instr_d       = instr_q;
    instr_valid_d = instr_valid_q;
    issue_d       = 1'b0;
    issue_count_d = issue_count_q;
    case (state_q)
      IDLE: begin
        if (!last_vld_q || bus.cur_add != last_add_q) begin
          last_add_d = bus.cur_add;
          last_vld_d = 1'b1;
          state_d    = FETCH;
        end
      end
      FETCH: begin
        instr_d       = store_rd;
        instr_valid_d = 1'b1;
        issue_d       = 1'b1;
        issue_count_d = issue_count_q + 8'd1;
        cnt_d         = CNT_INIT;
        state_d       = EXEC;
      end
      EXEC: begin
        if (cnt_q == 8'd0) begin
          instr_valid_d = 1'b0;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      last_add_q    <= '0;
      last_vld_q    <= 1'b0;
      cnt_q         <= '0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      issue_q       <= 1'b0;
      issue_count_q <= '0;
    end else begin
      state_q       <= state_d;
      last_add_q    <= last_add_d;
      last_vld_q    <= last_vld_d;
      cnt_q         <= cnt_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      issue_q       <= issue_d;
      issue_count_q <= issue_count_d;
    end
  end

  assign bus.instr       = instr_q;
  assign bus.instr_valid = instr_valid_q;
  assign bus.issue       = issue_q;
  assign bus.busy        = (state_q != IDLE);
  assign bus.issue_count = issue_count_q;

endmodule
